// File: rtl/counter_pkg.sv
// Shared encodings for the programmable-rate counter.
//   RATE_X1..RATE_X8 : rate_sel values selecting 1x/2x/4x/8x of the base step rate
//   DIR_UP/DIR_DOWN  : values of the 'up' input
package counter_pkg;

    localparam int unsigned RATE_SEL_W = 2;

    localparam logic [RATE_SEL_W-1:0] RATE_X1 = 2'd0;
    localparam logic [RATE_SEL_W-1:0] RATE_X2 = 2'd1;
    localparam logic [RATE_SEL_W-1:0] RATE_X4 = 2'd2;
    localparam logic [RATE_SEL_W-1:0] RATE_X8 = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/rate_prescaler.sv
// Prescaler producing one tick every (F_CLK_HZ/BASE_HZ) >> rate_sel cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : 1 = count, 0 = hold divider
//   clr        : synchronous divider clear (wins over en)
//   rate_sel   : period = TICKS_BASE >> rate_sel
//   tick       : combinational terminal-count strobe (en && terminal)
module rate_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned F_CLK_HZ = 50_000_000,
    parameter int unsigned BASE_HZ  = 4,
    parameter int unsigned DIV_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [RATE_SEL_W-1:0] rate_sel,
    output logic                  tick
);

    localparam int unsigned      TICKS_BASE   = F_CLK_HZ / BASE_HZ;
    localparam logic [DIV_W-1:0] TICKS_BASE_W = DIV_W'(TICKS_BASE);

    // Fastest rate must still give at least one cycle per step, and the divider must hold the period
    if ((TICKS_BASE >> 3) < 1) begin : g_bad_ticks
        $error("rate_prescaler: F_CLK_HZ/BASE_HZ too small for 8x rate");
    end
    if ((64'(TICKS_BASE) >> DIV_W) != 64'd0) begin : g_bad_div_w
        $error("rate_prescaler: DIV_W too narrow for F_CLK_HZ/BASE_HZ");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] ticks_m1;
    logic             term;

    // '>=' lets a mid-period rate increase terminate on the next edge instead of overrunning
    assign ticks_m1 = (TICKS_BASE_W >> rate_sel) - DIV_W'(1);
    assign term     = (div_q >= ticks_m1);
    assign tick     = en && term;

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = term ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/counter_rate_prog.sv
// Up/down counter over 0..MAX_VAL stepped by a programmable-rate prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run prescaler/counter; 0 holds state and zeroes pulses
//   up         : direction (DIR_UP / DIR_DOWN)
//   sat_mode   : 1 saturate at limits, 0 wrap
//   clear/load : synchronous clear / load of clamped load_val (clear wins, not gated by en)
//   rate_sel   : step rate = BASE_HZ << rate_sel
//   q          : registered count
//   step_p     : registered 1-cycle pulse per prescaler tick
//   wrap_p     : registered 1-cycle pulse when q wraps
//   at_limit   : combinational, q at the limit in the current direction
module counter_rate_prog
    import counter_pkg::*;
#(
    parameter int unsigned F_CLK_HZ = 50_000_000,
    parameter int unsigned BASE_HZ  = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 255,
    parameter int unsigned DIV_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  sat_mode,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [RATE_SEL_W-1:0] rate_sel,
    output logic [WIDTH-1:0]      q,
    output logic                  step_p,
    output logic                  wrap_p,
    output logic                  at_limit
);

    if ((64'(MAX_VAL) >> WIDTH) != 64'd0) begin : g_bad_max
        $error("counter_rate_prog: MAX_VAL does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             presc_clr;

    // Both clear and load restart the step period
    assign presc_clr = clear || load;

    rate_prescaler #(
        .F_CLK_HZ (F_CLK_HZ),
        .BASE_HZ  (BASE_HZ),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (presc_clr),
        .rate_sel (rate_sel),
        .tick     (tick)
    );

    // Next count and pulses: clear > load > tick > hold
    always_comb begin
        q_d    = q_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = (load_val > MAX_W) ? MAX_W : load_val;
        end else if (tick) begin
            step_d = 1'b1;
            if (up == DIR_UP) begin
                if (q_q != MAX_W) begin
                    q_d = q_q + WIDTH'(1);
                end else if (!sat_mode) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (q_q != '0) begin
                    q_d = q_q - WIDTH'(1);
                end else if (!sat_mode) begin
                    q_d    = MAX_W;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign q        = q_q;
    assign step_p   = step_q;
    assign wrap_p   = wrap_q;
    assign at_limit = ((up == DIR_UP) && (q_q == MAX_W)) || ((up == DIR_DOWN) && (q_q == '0));

endmodule
